// File: rtl/alu16_arbiter.sv
// Round-robin sequencer sharing one external alu16 datapath between two requesters.
// Optional carry chaining across operations is enabled by defining ALU16_ARB_CARRY_CHAIN_EN.
module alu16_arbiter #(
    parameter int SETTLE_CYCLES = 2,
    parameter int RR_RESET_PTR  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [7:0]  req_sel,
    input  logic [1:0]  req_mode,
    input  logic [1:0]  req_cin,
`ifdef ALU16_ARB_CARRY_CHAIN_EN
    input  logic [1:0]  req_chain,
`endif
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_cout,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_sel,
    output logic        alu_mode,
    output logic        alu_cin,
    input  logic [15:0] alu_result,
    input  logic        alu_cout,
    output logic        busy,
    output logic        grant_id
);

    localparam int         DATA_W      = 16;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state;
    logic              ptr;
    logic [3:0]        settle_cnt;
    logic              win_vld;
    logic              win_id;
    logic [DATA_W-1:0] win_a;
    logic [DATA_W-1:0] win_b;
    logic [3:0]        win_sel;
    logic              win_mode;
    logic              win_cin;
`ifdef ALU16_ARB_CARRY_CHAIN_EN
    logic [1:0]        cflag;
`endif

    // Logic-mode operations never carry, in either direction.
    function automatic logic gate_carry(input logic mode, input logic carry);
        return carry & ~mode;
    endfunction

    always_comb begin
        win_vld  = |req_valid;
        win_id   = (req_valid == 2'b11) ? ptr : req_valid[1];
        win_a    = win_id ? req_a[31:16] : req_a[15:0];
        win_b    = win_id ? req_b[31:16] : req_b[15:0];
        win_sel  = win_id ? req_sel[7:4] : req_sel[3:0];
        win_mode = req_mode[win_id];
`ifdef ALU16_ARB_CARRY_CHAIN_EN
        win_cin  = req_chain[win_id] ? cflag[win_id] : req_cin[win_id];
`else
        win_cin  = req_cin[win_id];
`endif
        req_ready = 2'b00;
        if (state == IDLE && win_vld)
            req_ready = win_id ? 2'b10 : 2'b01;
    end

    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= 1'(RR_RESET_PTR);
            settle_cnt <= '0;
            grant_id   <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            alu_mode   <= 1'b0;
            alu_cin    <= 1'b0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
`ifdef ALU16_ARB_CARRY_CHAIN_EN
            cflag      <= 2'b00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        alu_a      <= win_a;
                        alu_b      <= win_b;
                        alu_sel    <= win_sel;
                        alu_mode   <= win_mode;
                        alu_cin    <= gate_carry(win_mode, win_cin);
                        grant_id   <= win_id;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= ISSUE;
                    end
                end
                // ALU inputs stay frozen here while the external carry path resolves.
                ISSUE: begin
                    if (settle_cnt == 4'd0) begin
                        rsp_result <= alu_result;
                        rsp_cout   <= gate_carry(alu_mode, alu_cout);
                        state      <= RESP;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready[grant_id]) begin
                        state <= IDLE;
                        ptr   <= ~grant_id;
`ifdef ALU16_ARB_CARRY_CHAIN_EN
                        if (!alu_mode)
                            cflag[grant_id] <= rsp_cout;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu16_arbiter.sv
// Directed-vector bench for alu16_arbiter with a behavioural alu16 stub
// (arithmetic: a+b+cin, logic: a^b with carry-out forced high).
module tb_alu16_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  req_sel;
    logic [1:0]  req_mode;
    logic [1:0]  req_cin;
`ifdef ALU16_ARB_CARRY_CHAIN_EN
    logic [1:0]  req_chain;
`endif
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_cout;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_sel;
    logic        alu_mode;
    logic        alu_cin;
    logic [15:0] alu_result;
    logic        alu_cout;
    logic        busy;
    logic        grant_id;

    int checks = 0;
    int errors = 0;

    alu16_arbiter #(.SETTLE_CYCLES(2), .RR_RESET_PTR(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .req_mode   (req_mode),
        .req_cin    (req_cin),
`ifdef ALU16_ARB_CARRY_CHAIN_EN
        .req_chain  (req_chain),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_cout   (rsp_cout),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_mode   (alu_mode),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] stub_sum;
    always_comb begin
        stub_sum = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
        if (alu_mode) begin
            alu_result = alu_a ^ alu_b;
            alu_cout   = 1'b1;
        end else begin
            alu_result = stub_sum[15:0];
            alu_cout   = stub_sum[16];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int g, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] sel, input logic mode, input logic cin);
        req_a[16*g +: 16] = a;
        req_b[16*g +: 16] = b;
        req_sel[4*g +: 4] = sel;
        req_mode[g]       = mode;
        req_cin[g]        = cin;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rsp_result, rsp_cout, alu_a, alu_b, alu_sel, alu_mode, alu_cin} !== 55'd0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", {rsp_result, rsp_cout, alu_a, alu_b, alu_sel, alu_mode, alu_cin});
        end
        checks++;
        if ({req_ready, rsp_valid, busy, grant_id} !== 6'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 000000", {req_ready, rsp_valid, busy, grant_id});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy got %b required 0", busy);
        end
    endtask

    task automatic test_single_op;
        set_req(0, 16'h1234, 16'h0001, 4'b1001, 1'b0, 1'b0);
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_ready: got %b required 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if ({alu_a, alu_b, alu_sel, busy, rsp_valid} !== {16'h1234, 16'h0001, 4'b1001, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL single_issue1: got %h_%h sel %b busy %b vld %b required 1234_0001 1001 1 00", alu_a, alu_b, alu_sel, busy, rsp_valid);
        end
        tick();
        checks++;
        if ({alu_a, alu_b, rsp_valid} !== {16'h1234, 16'h0001, 2'b00}) begin
            errors++;
            $display("FAIL single_issue2: got %h_%h vld %b required 1234_0001 00", alu_a, alu_b, rsp_valid);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_result, rsp_cout} !== {2'b01, 16'h1235, 1'b0}) begin
            errors++;
            $display("FAIL single_resp: got vld %b res %h cout %b required 01 1235 0", rsp_valid, rsp_result, rsp_cout);
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        checks++;
        if ({busy, rsp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL single_done: got busy %b vld %b required 0 00", busy, rsp_valid);
        end
    endtask

    task automatic test_contention;
        logic [1:0]  exp_oh;
        logic [15:0] exp_res;
        rst_n = 1'b0;
        tick();
        set_req(0, 16'h0010, 16'h0001, 4'b1001, 1'b0, 1'b0);
        set_req(1, 16'h0020, 16'h0002, 4'b1001, 1'b0, 1'b0);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_oh  = (k % 2 == 1) ? 2'b10 : 2'b01;
            exp_res = (k % 2 == 1) ? 16'h0022 : 16'h0011;
            checks++;
            if (req_ready !== exp_oh) begin
                errors++;
                $display("FAIL contention_ready[%0d]: got %b required %b", k, req_ready, exp_oh);
            end
            tick();
            checks++;
            if ({grant_id, busy, req_ready} !== {exp_oh[1], 1'b1, 2'b00}) begin
                errors++;
                $display("FAIL contention_grant[%0d]: got id %b busy %b rdy %b required %b 1 00", k, grant_id, busy, req_ready, exp_oh[1]);
            end
            tick();
            tick();
            checks++;
            if ({rsp_valid, rsp_result} !== {exp_oh, exp_res}) begin
                errors++;
                $display("FAIL contention_resp[%0d]: got vld %b res %h required %b %h", k, rsp_valid, rsp_result, exp_oh, exp_res);
            end
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
    endtask

    task automatic test_backpressure;
        set_req(0, 16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b11;
        tick();
        tick();
        rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, req_ready, rsp_result} !== {2'b01, 2'b00, 16'h0100}) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: got vld %b rdy %b res %h required 01 00 0100", i, rsp_valid, req_ready, rsp_result);
            end
            tick();
        end
        rsp_ready = 2'b01;
        #1;
        checks++;
        if (rsp_valid !== 2'b01) begin
            errors++;
            $display("FAIL backpressure_release: got vld %b required 01", rsp_valid);
        end
        tick();
        rsp_ready = 2'b00;
        #1;
        checks++;
        if ({busy, req_ready} !== 3'b010) begin
            errors++;
            $display("FAIL backpressure_next: got busy %b rdy %b required 0 10", busy, req_ready);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_logic_mode;
        set_req(1, 16'hF0F0, 16'h0FF0, 4'b0110, 1'b1, 1'b1);
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL logic_ready: got %b required 10", req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if ({alu_mode, alu_cin, alu_sel} !== {1'b1, 1'b0, 4'b0110}) begin
            errors++;
            $display("FAIL logic_issue: got mode %b cin %b sel %b required 1 0 0110", alu_mode, alu_cin, alu_sel);
        end
        tick();
        tick();
        checks++;
        if ({rsp_valid, rsp_result, rsp_cout, grant_id} !== {2'b10, 16'hFF00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL logic_resp: got vld %b res %h cout %b id %b required 10 ff00 0 1", rsp_valid, rsp_result, rsp_cout, grant_id);
        end
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;
    endtask

    task automatic test_abort;
        set_req(0, 16'h0003, 16'h0004, 4'b1001, 1'b0, 1'b0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        checks++;
        if ({rsp_valid, rsp_result} !== {2'b01, 16'h0007}) begin
            errors++;
            $display("FAIL abort_pre: got vld %b res %h required 01 0007", rsp_valid, rsp_result);
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        set_req(1, 16'h0005, 16'h0003, 4'b1001, 1'b0, 1'b0);
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL abort_ptr_before: got %b required 10", req_ready);
        end
        tick();
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, grant_id, rsp_valid, alu_a, alu_b, alu_sel, alu_mode, alu_cin, rsp_result, rsp_cout} !== 59'd0) begin
            errors++;
            $display("FAIL abort_clear: got busy %b id %b vld %b alu %h_%h res %h required all 0", busy, grant_id, rsp_valid, alu_a, alu_b, rsp_result);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({rsp_valid, busy} !== 3'b000) begin
                errors++;
                $display("FAIL abort_quiet[%0d]: got vld %b busy %b required 00 0", i, rsp_valid, busy);
            end
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL abort_ptr_after: got %b required 01", req_ready);
        end
        req_valid = 2'b00;
        tick();
    endtask

`ifdef ALU16_ARB_CARRY_CHAIN_EN
    task automatic test_chain;
        req_chain = 2'b00;
        set_req(0, 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        checks++;
        if ({rsp_valid, rsp_result, rsp_cout} !== {2'b01, 16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL chain_step1: got vld %b res %h cout %b required 01 0000 1", rsp_valid, rsp_result, rsp_cout);
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        set_req(0, 16'h0000, 16'h0000, 4'b1001, 1'b0, 1'b0);
        req_chain = 2'b01;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        req_chain = 2'b00;
        checks++;
        if (alu_cin !== 1'b1) begin
            errors++;
            $display("FAIL chain_cin: got %b required 1", alu_cin);
        end
        tick();
        tick();
        checks++;
        if ({rsp_valid, rsp_result, rsp_cout} !== {2'b01, 16'h0001, 1'b0}) begin
            errors++;
            $display("FAIL chain_step2: got vld %b res %h cout %b required 01 0001 0", rsp_valid, rsp_result, rsp_cout);
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        req_mode  = '0;
        req_cin   = '0;
        rsp_ready = 2'b00;
`ifdef ALU16_ARB_CARRY_CHAIN_EN
        req_chain = 2'b00;
`endif
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_logic_mode();
        test_abort();
`ifdef ALU16_ARB_CARRY_CHAIN_EN
        test_chain();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
